// File: rtl/step_clk_pkg.sv
// ---------------------------------------------------------------------------
// step_clk_pkg
// Shared definitions for the alien-march step clock generator:
//   - FSM state encoding (3 bits, IDLE=0 .. ARM_SLOW=4)
//   - default half-period counts for a 50 MHz system clock
//   - default alien-count threshold for switching to the fast clock
//   - divider slot indices used by the top-level generate loop
// ---------------------------------------------------------------------------
package step_clk_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN_SLOW = 3'd1,
        ARM_FAST = 3'd2,
        RUN_FAST = 3'd3,
        ARM_SLOW = 3'd4
    } state_t;

    localparam int DEF_SLOW_HALF   = 25000000;  // 1 Hz at 50 MHz
    localparam int DEF_FAST_HALF   = 6250000;   // 4 Hz at 50 MHz
    localparam int DEF_CNT_W       = 25;
    localparam int DEF_ALIEN_W     = 6;
    localparam int DEF_FAST_THRESH = 8;

    // Divider slots inside the top-level generate loop
    localparam int SLOW_IDX = 0;
    localparam int FAST_IDX = 1;

endpackage

// File: rtl/clk_half_div.sv
// ---------------------------------------------------------------------------
// clk_half_div
// Half-period clock divider: a CNT_W-bit up-counter that wraps at HALF-1 and
// toggles DIV_OUT on the wrap, giving a 50% duty clock of period 2*HALF.
// While EN is low the counter and output are held at 0.
//
// Optional macro: STEP_TICK_EN adds the RISE output.
//
// Ports:
//   CLK     in   system clock
//   RST_N   in   asynchronous active-low reset
//   EN      in   divider enable; low clears counter and output
//   DIV_OUT out  registered divided clock
//   WRAP    out  high when DIV_OUT toggles on the coming edge
//   RISE    out  (STEP_TICK_EN only) registered pulse, high in the first
//                cycle DIV_OUT is high
// ---------------------------------------------------------------------------
module clk_half_div #(
    parameter int HALF  = 2,
    parameter int CNT_W = 25
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic EN,
    output logic DIV_OUT,
    output logic WRAP
`ifdef STEP_TICK_EN
    ,
    output logic RISE
`endif
);

    generate
        if (HALF < 1) begin : g_bad_half
            $error("clk_half_div: HALF must be at least 1");
        end
        if (HALF > (1 << CNT_W)) begin : g_bad_width
            $error("clk_half_div: CNT_W too narrow to hold HALF-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             out_reg;

    assign WRAP    = EN && (cnt_reg == LAST);
    assign DIV_OUT = out_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_reg <= '0;
            out_reg <= 1'b0;
        end else if (!EN) begin
            cnt_reg <= '0;
            out_reg <= 1'b0;
        end else if (WRAP) begin
            cnt_reg <= '0;
            out_reg <= ~out_reg;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

`ifdef STEP_TICK_EN
    logic rise_reg;

    // Set on the same edge DIV_OUT goes high, so it lines up with DIV_OUT.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rise_reg <= 1'b0;
        end else begin
            rise_reg <= WRAP && !out_reg;
        end
    end

    assign RISE = rise_reg;
`endif

endmodule

// File: rtl/step_clk_gen.sv
// ---------------------------------------------------------------------------
// step_clk_gen
// Generates the slow and fast alien-march step clocks plus the select line
// for the downstream clock mux. SEL only changes on an edge where both step
// clocks are low before the edge and neither toggles on it, so the muxed
// clock never glitches.
//
// Optional macro: STEP_TICK_EN adds STEP_TICK, a one-cycle clock-enable
// pulse one cycle after the selected step clock rises.
//
// Ports:
//   CLK          in   system clock
//   RST_N        in   asynchronous active-low reset
//   RUN          in   game running; low freezes both dividers, outputs low
//   ALIENS_LEFT  in   live alien count
//   SLOW_CLK     out  slow step clock (mux IN1)
//   FAST_CLK     out  fast step clock (mux IN2)
//   SEL          out  mux select, 0 = slow, 1 = fast
//   SEL_PENDING  out  high while a requested switch waits for a safe edge
//   STEP_TICK    out  (STEP_TICK_EN only) clock-enable pulse
// ---------------------------------------------------------------------------
module step_clk_gen
    import step_clk_pkg::*;
#(
    parameter int SLOW_HALF   = DEF_SLOW_HALF,
    parameter int FAST_HALF   = DEF_FAST_HALF,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int ALIEN_W     = DEF_ALIEN_W,
    parameter int FAST_THRESH = DEF_FAST_THRESH
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               RUN,
    input  logic [ALIEN_W-1:0] ALIENS_LEFT,
    output logic               SLOW_CLK,
    output logic               FAST_CLK,
    output logic               SEL,
    output logic               SEL_PENDING
`ifdef STEP_TICK_EN
    ,
    output logic               STEP_TICK
`endif
);

    localparam logic [31:0] THRESH_U = 32'(FAST_THRESH);

    state_t     state_reg;
    state_t     state_next;
    logic       sel_reg;
    logic       sel_next;
    logic       want_fast_reg;
    logic       div_en;
    logic       safe;
    logic [1:0] div_out;
    logic [1:0] div_wrap;
`ifdef STEP_TICK_EN
    logic [1:0] div_rise;
`endif

    // Dividers only run once the FSM has left IDLE, so the first toggle lands
    // HALF cycles after the first edge that samples RUN high.
    assign div_en = RUN && (state_reg != IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_div
            clk_half_div #(
                .HALF  ((gi == SLOW_IDX) ? SLOW_HALF : FAST_HALF),
                .CNT_W (CNT_W)
            ) u_div (
                .CLK     (CLK),
                .RST_N   (RST_N),
                .EN      (div_en),
                .DIV_OUT (div_out[gi]),
                .WRAP    (div_wrap[gi])
`ifdef STEP_TICK_EN
                ,
                .RISE    (div_rise[gi])
`endif
            );
        end
    endgenerate

    // Unsigned threshold compare, registered once before the FSM uses it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            want_fast_reg <= 1'b0;
        end else begin
            want_fast_reg <= (32'(ALIENS_LEFT) <= THRESH_U);
        end
    end

    // Both clocks low and neither about to toggle on this edge.
    assign safe = !div_out[SLOW_IDX] && !div_out[FAST_IDX] &&
                  !div_wrap[SLOW_IDX] && !div_wrap[FAST_IDX];

    // State register (SEL is registered alongside the state it belongs to)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            sel_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        if (!RUN) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Clocks are held low in IDLE, so SEL may change freely.
                    state_next = want_fast_reg ? RUN_FAST : RUN_SLOW;
                    sel_next   = want_fast_reg;
                end
                RUN_SLOW: begin
                    if (want_fast_reg) state_next = ARM_FAST;
                end
                ARM_FAST: begin
                    // A cancelled request wins over a coincident safe edge.
                    if (!want_fast_reg) begin
                        state_next = RUN_SLOW;
                    end else if (safe) begin
                        state_next = RUN_FAST;
                        sel_next   = 1'b1;
                    end
                end
                RUN_FAST: begin
                    if (!want_fast_reg) state_next = ARM_SLOW;
                end
                ARM_SLOW: begin
                    if (want_fast_reg) begin
                        state_next = RUN_FAST;
                    end else if (safe) begin
                        state_next = RUN_SLOW;
                        sel_next   = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        SLOW_CLK    = div_out[SLOW_IDX];
        FAST_CLK    = div_out[FAST_IDX];
        SEL         = sel_reg;
        SEL_PENDING = (state_reg == ARM_FAST) || (state_reg == ARM_SLOW);
    end

`ifdef STEP_TICK_EN
    logic step_tick_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            step_tick_reg <= 1'b0;
        end else begin
            step_tick_reg <= RUN && (sel_next == sel_reg) &&
                             (sel_reg ? div_rise[FAST_IDX] : div_rise[SLOW_IDX]);
        end
    end

    assign STEP_TICK = step_tick_reg;
`endif

endmodule

// File: tb/tb_step_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_step_clk_gen
// Directed bench for step_clk_gen with SLOW_HALF=8, FAST_HALF=2,
// FAST_THRESH=8. Edge numbering: e0 is the first edge that samples RUN=1;
// SLOW_CLK toggles every 8 edges after that, FAST_CLK every 2.
// ---------------------------------------------------------------------------
module tb_step_clk_gen;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       RUN = 1'b0;
    logic [5:0] ALIENS_LEFT = 6'd40;
    logic       SLOW_CLK;
    logic       FAST_CLK;
    logic       SEL;
    logic       SEL_PENDING;
`ifdef STEP_TICK_EN
    logic       STEP_TICK;
`endif

    int checks = 0;
    int errors = 0;

    step_clk_gen #(
        .SLOW_HALF   (8),
        .FAST_HALF   (2),
        .CNT_W       (5),
        .ALIEN_W     (6),
        .FAST_THRESH (8)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .RUN         (RUN),
        .ALIENS_LEFT (ALIENS_LEFT),
        .SLOW_CLK    (SLOW_CLK),
        .FAST_CLK    (FAST_CLK),
        .SEL         (SEL),
        .SEL_PENDING (SEL_PENDING)
`ifdef STEP_TICK_EN
        ,
        .STEP_TICK   (STEP_TICK)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // SEL may only move between two sample points where both clocks are low.
    logic sel_prev = 1'b0;
    logic slow_prev = 1'b0;
    logic fast_prev = 1'b0;
    always @(negedge CLK) begin
        if (RST_N && (SEL !== sel_prev)) begin
            checks++;
            assert (SLOW_CLK === 1'b0 && FAST_CLK === 1'b0 &&
                    slow_prev === 1'b0 && fast_prev === 1'b0) else begin
                errors++;
                $error("FAIL sel_edge_safe observed slow=%0b fast=%0b prev_slow=%0b prev_fast=%0b expected all 0",
                       SLOW_CLK, FAST_CLK, slow_prev, fast_prev);
            end
        end
        sel_prev  = SEL;
        slow_prev = SLOW_CLK;
        fast_prev = FAST_CLK;
    end

    initial begin
        // ---- reset state
        repeat (2) tick();
        chk("rst_slow", SLOW_CLK, 1'b0);
        chk("rst_fast", FAST_CLK, 1'b0);
        chk("rst_sel", SEL, 1'b0);
        chk("rst_pend", SEL_PENDING, 1'b0);
        $display("step reset: slow=%0b fast=%0b sel=%0b pend=%0b", SLOW_CLK, FAST_CLK, SEL, SEL_PENDING);
        #3 RST_N = 1'b1;
        tick();
        chk("idle_slow", SLOW_CLK, 1'b0);
        RUN = 1'b1;

        // ---- free run, slow selected: e0..e25
        for (int c = 0; c <= 25; c++) begin
            tick();
            chk("run_slow_clk", SLOW_CLK, ((c / 8) % 2) == 1);
            chk("run_fast_clk", FAST_CLK, ((c / 2) % 2) == 1);
            chk("run_sel", SEL, 1'b0);
            chk("run_pend", SEL_PENDING, 1'b0);
`ifdef STEP_TICK_EN
            chk("run_tick_slow", STEP_TICK, (c == 9) || (c == 25));
`endif
        end
        $display("step run: e25 slow=%0b fast=%0b sel=%0b", SLOW_CLK, FAST_CLK, SEL);

        // ---- request fast, then cancel before a safe edge
        ALIENS_LEFT = 6'd8;
        tick();                                  // e26
        chk("arm_pend_e26", SEL_PENDING, 1'b0);
        tick();                                  // e27
        chk("arm_pend_e27", SEL_PENDING, 1'b1);
        chk("arm_sel_e27", SEL, 1'b0);
        ALIENS_LEFT = 6'd40;
        tick();                                  // e28
        chk("cancel_pend_e28", SEL_PENDING, 1'b1);
        chk("cancel_sel_e28", SEL, 1'b0);
        tick();                                  // e29
        chk("cancel_pend_e29", SEL_PENDING, 1'b0);
        chk("cancel_sel_e29", SEL, 1'b0);
        $display("step cancel: sel=%0b pend=%0b", SEL, SEL_PENDING);

        // ---- request fast, wait for the safe edge
        ALIENS_LEFT = 6'd8;
        tick();                                  // e30
        chk("sw_pend_e30", SEL_PENDING, 1'b0);
        tick();                                  // e31
        chk("sw_pend_e31", SEL_PENDING, 1'b1);
        chk("sw_sel_e31", SEL, 1'b0);
        chk("sw_slow_e31", SLOW_CLK, 1'b1);
        tick();                                  // e32: slow falls, not yet safe
        chk("sw_pend_e32", SEL_PENDING, 1'b1);
        chk("sw_sel_e32", SEL, 1'b0);
        chk("sw_slow_e32", SLOW_CLK, 1'b0);
        tick();                                  // e33: first safe edge
        chk("sw_sel_e33", SEL, 1'b1);
        chk("sw_pend_e33", SEL_PENDING, 1'b0);
        chk("sw_fast_e33", FAST_CLK, 1'b0);
        $display("step switch: sel=%0b pend=%0b", SEL, SEL_PENDING);

        // ---- RUN low with FAST_CLK high, then restart
        tick();                                  // e34
        chk("stop_fast_hi", FAST_CLK, 1'b1);
        RUN = 1'b0;
        tick();                                  // e35
        chk("stop_slow", SLOW_CLK, 1'b0);
        chk("stop_fast", FAST_CLK, 1'b0);
        chk("stop_sel_hold", SEL, 1'b1);
        chk("stop_pend", SEL_PENDING, 1'b0);
        $display("step stop: slow=%0b fast=%0b sel=%0b", SLOW_CLK, FAST_CLK, SEL);
        RUN = 1'b1;
        for (int r = 0; r <= 9; r++) begin
            tick();                              // e36 + r
            chk("rs_slow_clk", SLOW_CLK, ((r / 8) % 2) == 1);
            chk("rs_fast_clk", FAST_CLK, ((r / 2) % 2) == 1);
            chk("rs_sel", SEL, 1'b1);
            chk("rs_pend", SEL_PENDING, 1'b0);
`ifdef STEP_TICK_EN
            chk("rs_tick_fast", STEP_TICK, (r == 3) || (r == 7));
`endif
        end
        $display("step restart: slow=%0b fast=%0b sel=%0b", SLOW_CLK, FAST_CLK, SEL);

        // ---- enter ARM_SLOW, then async reset between edges
        ALIENS_LEFT = 6'd40;
        tick();                                  // e46
        chk("arms_pend_e46", SEL_PENDING, 1'b0);
        tick();                                  // e47
        chk("arms_pend_e47", SEL_PENDING, 1'b1);
        chk("arms_sel_e47", SEL, 1'b1);
        chk("arms_slow_e47", SLOW_CLK, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_slow", SLOW_CLK, 1'b0);
        chk("arst_fast", FAST_CLK, 1'b0);
        chk("arst_sel", SEL, 1'b0);
        chk("arst_pend", SEL_PENDING, 1'b0);
        $display("step async reset: slow=%0b fast=%0b sel=%0b pend=%0b", SLOW_CLK, FAST_CLK, SEL, SEL_PENDING);
        #3 RST_N = 1'b1;
        tick();
        chk("post_sel", SEL, 1'b0);
        chk("post_slow", SLOW_CLK, 1'b0);
        chk("post_fast", FAST_CLK, 1'b0);
        chk("post_pend", SEL_PENDING, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
